// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the dual-issue instruction queue.
// inst_t fixes the record width; IQ_DEPTH is the default entry count.
package inst_queue_pkg;

   typedef struct packed {
      logic [29:0] pc;
      logic [31:0] word;
      logic        pred_valid;
      logic        pred_taken;
   } inst_t;

   localparam int unsigned IQ_DEPTH = 8;
   localparam int unsigned IQ_WIDTH = $bits(inst_t);

   function automatic logic [1:0] popcnt2(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

   // An issue request of 3 is treated as 2.
   function automatic logic [1:0] clamp_issue(input logic [1:0] n);
      return (n == 2'd3) ? 2'd2 : n;
   endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side and issue-side signals of the instruction queue.
// The slave modport is the queue; the master modport is its environment.
interface inst_queue_if import inst_queue_pkg::*; #(
   parameter int unsigned WIDTH = IQ_WIDTH,
   parameter int unsigned DEPTH = IQ_DEPTH
) ();

   logic                       flush_i;
   logic [1:0][WIDTH-1:0]      in_data_i;
   logic [1:0]                 in_valid_i;
   logic                       in_ready_o;
   logic [1:0][WIDTH-1:0]      out_data_o;
   logic [1:0]                 out_valid_o;
   logic [1:0]                 issue_num_i;
   logic [$clog2(DEPTH):0]     count_o;

   modport slave (
      input  flush_i, in_data_i, in_valid_i, issue_num_i,
      output in_ready_o, out_data_o, out_valid_o, count_o
   );

   modport master (
      output flush_i, in_data_i, in_valid_i, issue_num_i,
      input  in_ready_o, out_data_o, out_valid_o, count_o
   );

endinterface

// File: rtl/inst_queue_ram.sv
// DEPTH x WIDTH register file for the instruction queue.
// Two write ports with per-port enables, two asynchronous read ports; no reset.
module iq_ram #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     we0,
   input  logic [$clog2(DEPTH)-1:0] waddr0,
   input  logic [WIDTH-1:0]         wdata0,
   input  logic                     we1,
   input  logic [$clog2(DEPTH)-1:0] waddr1,
   input  logic [WIDTH-1:0]         wdata1,
   input  logic [$clog2(DEPTH)-1:0] raddr0,
   output logic [WIDTH-1:0]         rdata0,
   input  logic [$clog2(DEPTH)-1:0] raddr1,
   output logic [WIDTH-1:0]         rdata1
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Callers never enable both ports at the same address.
   always_ff @(posedge clk) begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_queue.sv
// Dual-issue instruction queue between fetch and decode/issue.
// Accepts up to two instructions per cycle and presents the two oldest.
module inst_queue import inst_queue_pkg::*; #(
   parameter int unsigned WIDTH = IQ_WIDTH,
   parameter int unsigned DEPTH = IQ_DEPTH
) (
   input  logic         clk,
   input  logic         rst_n,
   inst_queue_if.slave  bus
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             in_ready;
   logic             push_en;
   logic [1:0]       push_n, avail_n, pop_n;

   logic             we0, we1;
   logic [PW-1:0]    waddr1, raddr1;
   logic [WIDTH-1:0] wdata0;
   logic [WIDTH-1:0] rdata0, rdata1;

   // Readiness looks only at the registered count, keeping issue_num_i off this path.
   always_comb begin
      in_ready = (count <= CW'(DEPTH - 2));
      push_en  = in_ready && (|bus.in_valid_i) && !bus.flush_i;
      push_n   = push_en ? popcnt2(bus.in_valid_i) : 2'd0;
      avail_n  = (count >= CW'(2)) ? 2'd2 : count[1:0];
      pop_n    = clamp_issue(bus.issue_num_i);
      if (pop_n > avail_n) pop_n = avail_n;
      if (bus.flush_i)     pop_n = 2'd0;
   end

   // Compaction: the oldest valid slot always lands at wr_ptr via port 0.
   always_comb begin
      we0    = push_en;
      wdata0 = bus.in_valid_i[0] ? bus.in_data_i[0] : bus.in_data_i[1];
      we1    = push_en && (&bus.in_valid_i);
      waddr1 = wr_ptr + PW'(1);
      raddr1 = rd_ptr + PW'(1);
   end

   iq_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk    (clk),
      .we0    (we0),
      .waddr0 (wr_ptr),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (waddr1),
      .wdata1 (bus.in_data_i[1]),
      .raddr0 (rd_ptr),
      .rdata0 (rdata0),
      .raddr1 (raddr1),
      .rdata1 (rdata1)
   );

   always_ff @(posedge clk) begin
      if (!rst_n || bus.flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push_n);
         rd_ptr <= rd_ptr + PW'(pop_n);
         count  <= count + CW'(push_n) - CW'(pop_n);
      end
   end

   assign bus.in_ready_o     = in_ready;
   assign bus.count_o        = count;
   assign bus.out_valid_o    = {count >= CW'(2), count >= CW'(1)};
   assign bus.out_data_o[0]  = rdata0;
   assign bus.out_data_o[1]  = rdata1;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed steps push hand-computed expectations,
// a negedge monitor pops and compares them against the queue outputs.
module tb_inst_queue;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   inst_queue_if #(.WIDTH(64), .DEPTH(8)) bus ();

   inst_queue #(.WIDTH(64), .DEPTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int unsigned cyc;
      string       name;
      logic [3:0]  cnt;
      logic [1:0]  vld;
      logic        rdy;
      logic [63:0] h0;
      logic [63:0] h1;
   } exp_t;

   exp_t        sb[$];
   int unsigned scyc = 0;
   int unsigned mcyc = 0;
   int          checks = 0;
   int          failures = 0;
   bit          stim_done = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // One stimulus cycle; the expectation describes the state visible after the next posedge.
   task automatic step(input string name, input bit r, input bit f, input logic [1:0] v,
                       input logic [63:0] a, input logic [63:0] b, input logic [1:0] iss,
                       input int ecnt, input logic [63:0] eh0, input logic [63:0] eh1);
      exp_t e;
      @(negedge clk);
      scyc++;
      rst_n            = r;
      bus.flush_i      = f;
      bus.in_valid_i   = v;
      bus.in_data_i[0] = a;
      bus.in_data_i[1] = b;
      bus.issue_num_i  = iss;
      e.cyc  = scyc + 1;
      e.name = name;
      e.cnt  = 4'(ecnt);
      e.vld  = (ecnt >= 2) ? 2'b11 : (ecnt == 1) ? 2'b01 : 2'b00;
      e.rdy  = (ecnt <= 6);
      e.h0   = eh0;
      e.h1   = eh1;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      mcyc++;
      while (sb.size() > 0 && sb[0].cyc <= mcyc) begin
         exp_t e;
         e = sb.pop_front();
         chk({e.name, ".count"}, 64'(bus.count_o), 64'(e.cnt));
         chk({e.name, ".valid"}, 64'(bus.out_valid_o), 64'(e.vld));
         chk({e.name, ".ready"}, 64'(bus.in_ready_o), 64'(e.rdy));
         if (e.vld[0]) chk({e.name, ".head0"}, bus.out_data_o[0], e.h0);
         if (e.vld[1]) chk({e.name, ".head1"}, bus.out_data_o[1], e.h1);
      end
   end

   initial begin
      rst_n            = 1'b0;
      bus.flush_i      = 1'b0;
      bus.in_valid_i   = 2'b00;
      bus.in_data_i[0] = '0;
      bus.in_data_i[1] = '0;
      bus.issue_num_i  = 2'd0;

      //    name      rst flush vld  slot0   slot1   iss  cnt head0   head1
      step("rst0",    0,  0, 2'b00, 64'h0,  64'h0,  2'd0, 0, 64'h0,  64'h0);
      step("rst1",    0,  0, 2'b11, 64'h1,  64'h2,  2'd0, 0, 64'h0,  64'h0);
      step("idle",    1,  0, 2'b00, 64'h0,  64'h0,  2'd0, 0, 64'h0,  64'h0);
      step("fill2",   1,  0, 2'b11, 64'hA0, 64'hA1, 2'd0, 2, 64'hA0, 64'hA1);
      step("fill4",   1,  0, 2'b11, 64'hA2, 64'hA3, 2'd0, 4, 64'hA0, 64'hA1);
      step("fill6",   1,  0, 2'b11, 64'hA4, 64'hA5, 2'd0, 6, 64'hA0, 64'hA1);
      step("fill8",   1,  0, 2'b11, 64'hA6, 64'hA7, 2'd0, 8, 64'hA0, 64'hA1);
      step("full",    1,  0, 2'b11, 64'hA,  64'hB,  2'd0, 8, 64'hA0, 64'hA1);
      step("pop2",    1,  0, 2'b00, 64'h0,  64'h0,  2'd2, 6, 64'hA2, 64'hA3);
      step("pushpop", 1,  0, 2'b11, 64'hB0, 64'hB1, 2'd2, 6, 64'hA4, 64'hA5);
      step("drain4",  1,  0, 2'b00, 64'h0,  64'h0,  2'd2, 4, 64'hA6, 64'hA7);
      step("wrap",    1,  0, 2'b00, 64'h0,  64'h0,  2'd2, 2, 64'hB0, 64'hB1);
      step("iss3",    1,  0, 2'b00, 64'h0,  64'h0,  2'd3, 0, 64'h0,  64'h0);
      step("mix11",   1,  0, 2'b11, 64'hC0, 64'hC1, 2'd0, 2, 64'hC0, 64'hC1);
      step("mix10",   1,  0, 2'b10, 64'hDEAD, 64'hC2, 2'd0, 3, 64'hC0, 64'hC1);
      step("iss1",    1,  0, 2'b00, 64'h0,  64'h0,  2'd1, 2, 64'hC1, 64'hC2);
      step("mix01",   1,  0, 2'b01, 64'hC3, 64'hBEEF, 2'd0, 3, 64'hC1, 64'hC2);
      step("pop_to1", 1,  0, 2'b00, 64'h0,  64'h0,  2'd2, 1, 64'hC3, 64'h0);
      step("overiss", 1,  0, 2'b00, 64'h0,  64'h0,  2'd2, 0, 64'h0,  64'h0);
      step("f_fill2", 1,  0, 2'b11, 64'hE0, 64'hE1, 2'd0, 2, 64'hE0, 64'hE1);
      step("f_fill4", 1,  0, 2'b11, 64'hE2, 64'hE3, 2'd0, 4, 64'hE0, 64'hE1);
      step("f_fill5", 1,  0, 2'b01, 64'hE4, 64'h0,  2'd0, 5, 64'hE0, 64'hE1);
      step("flush",   1,  1, 2'b11, 64'hD0, 64'hD1, 2'd2, 0, 64'h0,  64'h0);
      step("postfl",  1,  0, 2'b11, 64'hF0, 64'hF1, 2'd0, 2, 64'hF0, 64'hF1);
      step("midrst",  0,  0, 2'b11, 64'h5,  64'h6,  2'd1, 0, 64'h0,  64'h0);
      step("final",   1,  0, 2'b00, 64'h0,  64'h0,  2'd0, 0, 64'h0,  64'h0);
      stim_done = 1'b1;
   end

   initial begin
      wait (stim_done);
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=%0d checks want=completion", checks);
      $fatal(1, "timeout");
   end

endmodule
